// File: rtl/vx_csr_access_ctrl.sv
// vx_csr_access_ctrl
//   Sequences a single CSR read-modify-write access: accept a request, read
//   the CSR, compute the new value (RW / RS / RC), optionally write it back,
//   then return the old value on the response port. One request in flight.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   req_*             : request in (valid/ready), op/uuid/wid/addr/rd_nz/src
//   read_*            : read strobe + ids/address out, ro/rw data in (same cycle)
//   write_*           : write strobe + ids/address/new value out
//   rsp_*             : response out (valid/ready), uuid/wid/old data/illegal

`ifndef XLEN
`define XLEN 32
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif
`ifndef STRING
`define STRING string
`endif

module vx_csr_access_ctrl #(
    parameter `STRING INSTANCE_ID = ""
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [`UUID_WIDTH-1:0]       req_uuid,
    input  logic [`NW_WIDTH-1:0]         req_wid,
    input  logic [`VX_CSR_ADDR_BITS-1:0] req_addr,
    input  logic                         req_rd_nz,
    input  logic [`XLEN-1:0]             req_src,

    output logic                         read_enable,
    output logic [`UUID_WIDTH-1:0]       read_uuid,
    output logic [`NW_WIDTH-1:0]         read_wid,
    output logic [`VX_CSR_ADDR_BITS-1:0] read_addr,
    input  logic [`XLEN-1:0]             read_data_ro,
    input  logic [`XLEN-1:0]             read_data_rw,

    output logic                         write_enable,
    output logic [`UUID_WIDTH-1:0]       write_uuid,
    output logic [`NW_WIDTH-1:0]         write_wid,
    output logic [`VX_CSR_ADDR_BITS-1:0] write_addr,
    output logic [`XLEN-1:0]             write_data,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [`UUID_WIDTH-1:0]       rsp_uuid,
    output logic [`NW_WIDTH-1:0]         rsp_wid,
    output logic [`XLEN-1:0]             rsp_data,
    output logic                         rsp_illegal
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RSP} state_t;

    state_t state, state_n;

    logic [1:0]                   op_p0;
    logic [`UUID_WIDTH-1:0]       uuid_p0;
    logic [`NW_WIDTH-1:0]         wid_p0;
    logic [`VX_CSR_ADDR_BITS-1:0] addr_p0;
    logic [`XLEN-1:0]             src_p0;

    logic [`XLEN-1:0]             new_p1;
    logic [`XLEN-1:0]             old_p1;
    logic                         illegal_p1;

    logic                         fire;
    logic [`XLEN-1:0]             old_val;
    logic                         do_write;
    logic                         ro_addr;

    // rd_nz has no bearing on access control; accepted for interface parity.
    logic unused_req_rd_nz;
    assign unused_req_rd_nz = req_rd_nz;

    function automatic logic [`XLEN-1:0] calc_new(
        input logic [1:0]       op,
        input logic [`XLEN-1:0] old_v,
        input logic [`XLEN-1:0] src_v
    );
        case (op)
            OP_RW:   calc_new = src_v;
            OP_RS:   calc_new = old_v | src_v;
            default: calc_new = old_v & ~src_v;
        endcase
    endfunction

    assign fire     = req_valid && req_ready;
    assign old_val  = read_data_ro | read_data_rw;
    // A set/clear with a zero mask is a pure read and must not touch the CSR.
    assign do_write = (op_p0 == OP_RW) || (src_p0 != '0);
    assign ro_addr  = (addr_p0[11:10] == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Strobes are forced low while reset is held so an in-flight access is
    // dropped without a late read/write/response.
    always_comb begin
        state_n      = state;
        req_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = (req_op == 2'b00) ? ST_RSP : ST_READ;
                end
            end
            ST_READ: begin
                read_enable = 1'b1;
                state_n     = (do_write && !ro_addr) ? ST_WRITE : ST_RSP;
            end
            ST_WRITE: begin
                write_enable = 1'b1;
                state_n      = ST_RSP;
            end
            default: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
        endcase
        if (reset) begin
            req_ready    = 1'b0;
            read_enable  = 1'b0;
            write_enable = 1'b0;
            rsp_valid    = 1'b0;
            state_n      = ST_IDLE;
        end
    end

    // Stage p0: request capture at fire
    always_ff @(posedge clk) begin
        if (fire) begin
            op_p0   <= req_op;
            uuid_p0 <= req_uuid;
            wid_p0  <= req_wid;
            addr_p0 <= req_addr;
            src_p0  <= req_src;
        end
    end

    // Stage p1: read result and new value
    always_ff @(posedge clk) begin
        if (state == ST_READ) begin
            new_p1 <= calc_new(op_p0, old_val, src_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            old_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (fire) begin
            old_p1     <= '0;
            illegal_p1 <= (req_op == 2'b00);
        end else if (state == ST_READ) begin
            old_p1     <= old_val;
            illegal_p1 <= ro_addr && do_write;
        end
    end

    // Side fields are zeroed when their strobe is low so they never carry X
    // from the unreset capture registers.
    assign read_uuid   = read_enable  ? uuid_p0 : '0;
    assign read_wid    = read_enable  ? wid_p0  : '0;
    assign read_addr   = read_enable  ? addr_p0 : '0;
    assign write_uuid  = write_enable ? uuid_p0 : '0;
    assign write_wid   = write_enable ? wid_p0  : '0;
    assign write_addr  = write_enable ? addr_p0 : '0;
    assign write_data  = write_enable ? new_p1  : '0;
    assign rsp_uuid    = rsp_valid    ? uuid_p0 : '0;
    assign rsp_wid     = rsp_valid    ? wid_p0  : '0;
    assign rsp_data    = old_p1;
    assign rsp_illegal = rsp_valid && illegal_p1;

`ifndef SYNTHESIS
    rsp_hold_a: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> rsp_valid)
        else $error("[%s] rsp_valid dropped without rsp_ready", INSTANCE_ID);

    strobe_excl_a: assert property (@(posedge clk) disable iff (reset)
        !(read_enable && write_enable))
        else $error("[%s] read_enable and write_enable overlap", INSTANCE_ID);
`endif

endmodule

// File: tb/tb_vx_csr_access_ctrl.sv
`timescale 1ns/1ps
module tb_vx_csr_access_ctrl;
    localparam int XW  = 32;
    localparam int UW  = 44;
    localparam int NWW = 2;
    localparam int AW  = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_rd_nz;
    logic [1:0]     req_op;
    logic [UW-1:0]  req_uuid;
    logic [NWW-1:0] req_wid;
    logic [AW-1:0]  req_addr;
    logic [XW-1:0]  req_src;
    logic           read_enable, write_enable, rsp_valid, rsp_ready, rsp_illegal;
    logic [UW-1:0]  read_uuid, write_uuid, rsp_uuid;
    logic [NWW-1:0] read_wid, write_wid, rsp_wid;
    logic [AW-1:0]  read_addr, write_addr;
    logic [XW-1:0]  read_data_ro, read_data_rw, write_data, rsp_data;
    logic [XW-1:0]  ro_val, rw_val;

    always #5 clk = ~clk;

    // Garbage outside the read cycle so a mistimed capture shows up.
    assign read_data_ro = read_enable ? ro_val : 32'hDEAD_0000;
    assign read_data_rw = read_enable ? rw_val : 32'h0000_BEEF;

    vx_csr_access_ctrl #(.INSTANCE_ID("tb")) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_uuid(req_uuid), .req_wid(req_wid), .req_addr(req_addr),
        .req_rd_nz(req_rd_nz), .req_src(req_src),
        .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid),
        .read_addr(read_addr), .read_data_ro(read_data_ro), .read_data_rw(read_data_rw),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
        .write_addr(write_addr), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
        .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
    );

    typedef struct {
        logic [UW-1:0]  uuid;
        logic [NWW-1:0] wid;
        logic [AW-1:0]  addr;
        bit             exp_read;
        bit             exp_write;
        logic [XW-1:0]  wdata;
        logic [XW-1:0]  rdata;
        bit             illegal;
        int             lat;
        bit             abort;
    } exp_t;

    exp_t          exp_q[$];
    int            cmp_cnt = 0;
    int            mis_cnt = 0;
    int            cyc = 0;
    logic [UW-1:0] next_uuid = 44'h100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        cmp_cnt++;
        if (got !== want) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit             in_flight = 0;
    exp_t           cur;
    int             fire_cyc;
    bit             saw_read, saw_write, rsp_seen;
    logic [XW-1:0]  hold_data;
    logic           hold_ill;
    logic [UW-1:0]  hold_uuid;
    logic [NWW-1:0] hold_wid;

    always @(negedge clk) begin
        if (reset) begin
            if (in_flight) begin
                chk("abort_expected", 64'(cur.abort), 64'd1);
                in_flight = 0;
            end
        end else begin
            if (read_enable && write_enable) chk("strobe_overlap", 64'd1, 64'd0);
            if (read_enable) begin
                if (!in_flight || !cur.exp_read || saw_read) chk("unexpected_read", 64'd1, 64'd0);
                else begin
                    saw_read = 1;
                    chk("read_cycle", 64'(cyc - fire_cyc), 64'd1);
                    chk("read_addr", 64'(read_addr), 64'(cur.addr));
                    chk("read_uuid", 64'(read_uuid), 64'(cur.uuid));
                    chk("read_wid",  64'(read_wid),  64'(cur.wid));
                end
            end
            if (write_enable) begin
                if (!in_flight || !cur.exp_write || saw_write) chk("unexpected_write", 64'd1, 64'd0);
                else begin
                    saw_write = 1;
                    chk("write_cycle", 64'(cyc - fire_cyc), 64'd2);
                    chk("write_data", 64'(write_data), 64'(cur.wdata));
                    chk("write_addr", 64'(write_addr), 64'(cur.addr));
                    chk("write_uuid", 64'(write_uuid), 64'(cur.uuid));
                    chk("write_wid",  64'(write_wid),  64'(cur.wid));
                end
            end
            if (rsp_valid) begin
                if (!in_flight) chk("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    chk("req_ready_during_rsp", 64'(req_ready), 64'd0);
                    if (!rsp_seen) begin
                        rsp_seen  = 1;
                        chk("rsp_latency", 64'(cyc - fire_cyc), 64'(cur.lat));
                        hold_data = rsp_data;
                        hold_ill  = rsp_illegal;
                        hold_uuid = rsp_uuid;
                        hold_wid  = rsp_wid;
                    end else begin
                        chk("rsp_data_stable", 64'(rsp_data), 64'(hold_data));
                        chk("rsp_ill_stable",  64'(rsp_illegal), 64'(hold_ill));
                        chk("rsp_uuid_stable", 64'(rsp_uuid), 64'(hold_uuid));
                        chk("rsp_wid_stable",  64'(rsp_wid), 64'(hold_wid));
                    end
                    if (rsp_ready) begin
                        chk("rsp_data",    64'(rsp_data), 64'(cur.rdata));
                        chk("rsp_illegal", 64'(rsp_illegal), 64'(cur.illegal));
                        chk("rsp_uuid",    64'(rsp_uuid), 64'(cur.uuid));
                        chk("rsp_wid",     64'(rsp_wid), 64'(cur.wid));
                        chk("read_seen",   64'(saw_read), 64'(cur.exp_read));
                        chk("write_seen",  64'(saw_write), 64'(cur.exp_write));
                        in_flight = 0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                if (in_flight) chk("fire_while_busy", 64'd1, 64'd0);
                else if (exp_q.size() == 0) chk("fire_without_expect", 64'd1, 64'd0);
                else begin
                    cur       = exp_q.pop_front();
                    in_flight = 1;
                    fire_cyc  = cyc;
                    saw_read  = 0;
                    saw_write = 0;
                    rsp_seen  = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [XW-1:0] src, input bit exp_write,
                         input logic [XW-1:0] wdata, input logic [XW-1:0] rdata,
                         input bit illegal, input int lat, input bit abort);
        exp_t e;
        bit   fired = 0;
        e.uuid      = next_uuid;
        e.wid       = next_uuid[NWW-1:0];
        e.addr      = addr;
        e.exp_read  = (op != 2'b00);
        e.exp_write = exp_write;
        e.wdata     = wdata;
        e.rdata     = rdata;
        e.illegal   = illegal;
        e.lat       = lat;
        e.abort     = abort;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_uuid  = e.uuid;
        req_wid   = e.wid;
        req_addr  = addr;
        req_src   = src;
        req_rd_nz = 1'b1;
        next_uuid = next_uuid + 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                fired = 1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!fired) begin
            chk("issue_timeout", 64'd0, 64'd1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (!in_flight && exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (in_flight || exp_q.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_uuid  = '0;
        req_wid   = '0;
        req_addr  = '0;
        req_src   = '0;
        req_rd_nz = 1'b0;
        rsp_ready = 1'b1;
        ro_val    = '0;
        rw_val    = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_read_en",   64'(read_enable), 64'd0);
        chk("reset_write_en",  64'(write_enable), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 64'(req_ready), 64'd1);
        chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_reset_rsp_ill",   64'(rsp_illegal), 64'd0);
        chk("post_reset_rsp_data",  64'(rsp_data), 64'd0);
        @(posedge clk); #1;

        // RW: write src, respond with old
        rw_val = 32'hF0; ro_val = 32'h0;
        issue(2'b01, 12'h340, 32'h1234, 1, 32'h1234, 32'hF0, 0, 3, 0);
        drain();
        // RS with zero mask: read only
        issue(2'b10, 12'h340, 32'h0, 0, 32'h0, 32'hF0, 0, 2, 0);
        drain();
        // RC then RS
        issue(2'b11, 12'h340, 32'h30, 1, 32'hC0, 32'hF0, 0, 3, 0);
        drain();
        rw_val = 32'hC0;
        issue(2'b10, 12'h340, 32'h5, 1, 32'hC5, 32'hC0, 0, 3, 0);
        drain();
        // full-width set / clear
        rw_val = 32'h1;
        issue(2'b10, 12'h305, 32'h8000_0000, 1, 32'h8000_0001, 32'h1, 0, 3, 0);
        drain();
        rw_val = 32'hF0;
        issue(2'b11, 12'h305, 32'hFFFF_FFFF, 1, 32'h0, 32'hF0, 0, 3, 0);
        drain();
        // read-only CSR
        rw_val = 32'h0; ro_val = 32'h1234_5678;
        issue(2'b01, 12'hC00, 32'h9, 0, 32'h0, 32'h1234_5678, 1, 2, 0);
        drain();
        issue(2'b10, 12'hC00, 32'h0, 0, 32'h0, 32'h1234_5678, 0, 2, 0);
        drain();
        issue(2'b11, 12'hC01, 32'h1, 0, 32'h0, 32'h1234_5678, 1, 2, 0);
        drain();
        // reserved op
        issue(2'b00, 12'h340, 32'h7, 0, 32'h0, 32'h0, 1, 1, 0);
        drain();

        // response back-pressure with a second request waiting
        ro_val = 32'h0; rw_val = 32'h55;
        rsp_ready = 1'b0;
        fork
            begin
                issue(2'b01, 12'h341, 32'hAA, 1, 32'hAA, 32'h55, 0, 3, 0);
                issue(2'b10, 12'h341, 32'h0, 0, 32'h0, 32'h55, 0, 2, 0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (rsp_valid) break;
                end
                repeat (5) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();

        // reset during the write cycle
        rw_val = 32'h10;
        issue(2'b01, 12'h340, 32'h77, 1, 32'h77, 32'h10, 0, 3, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_write_we",  64'(write_enable), 64'd0);
        chk("reset_in_write_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_abort_req_ready", 64'(req_ready), 64'd1);
        chk("after_abort_read_en",   64'(read_enable), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_abort_no_rsp", 64'(rsp_valid), 64'd0);
            chk("after_abort_no_we",  64'(write_enable), 64'd0);
        end
        @(posedge clk); #1;

        // normal operation resumes
        rw_val = 32'h3;
        issue(2'b10, 12'h340, 32'h4, 1, 32'h7, 32'h3, 0, 3, 0);
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
